// File: rtl/sm83_irq_resp_if.sv
// Core-side bus, peripheral request and clock-gating signals seen by the SM83 interrupt responder.
interface sm83_irq_resp_if #(
    parameter int NUM_SRC = 5
);
    logic [15:0]        adr;
    logic [7:0]         din;
    logic [7:0]         dout;
    logic               dout_oe;
    logic               rd;
    logic               wr;
    logic [NUM_SRC-1:0] src_req;
    logic [7:0]         irq;
    logic [7:0]         iack;
    logic               clk_ena;
    logic               clk_stable;

    modport master (
        output adr, din, rd, wr, src_req, iack, clk_ena,
        input  dout, dout_oe, irq, clk_stable
    );

    modport slave (
        input  adr, din, rd, wr, src_req, iack, clk_ena,
        output dout, dout_oe, irq, clk_stable
    );
endinterface

// File: rtl/sm83_irq_resp.sv
// SM83 interrupt-flag register with request edge capture, iack clearing,
// and oscillator-restart timing after the core drops clk_ena.
module sm83_irq_bit (
    input  logic clk,
    input  logic areset,
    input  logic req,
    input  logic wr_hit,
    input  logic wdat,
    input  logic ack,
    output logic flag
);
    logic req_q;

    // A rising request beats a same-cycle write or acknowledge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            req_q <= 1'b0;
            flag  <= 1'b0;
        end else begin
            req_q <= req;
            if (req && !req_q)
                flag <= 1'b1;
            else if (wr_hit)
                flag <= wdat;
            else if (ack)
                flag <= 1'b0;
        end
    end
endmodule

module sm83_irq_resp #(
    parameter int          NUM_SRC       = 5,
    parameter logic [15:0] IF_ADR        = 16'hFF0F,
    parameter int          STABLE_CYCLES = 16
) (
    input  logic           clk,
    input  logic           areset,
    sm83_irq_resp_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COUNT, STABLE} state_t;

    logic               hit;
    logic               wr_hit;
    logic [NUM_SRC-1:0] if_q;
    logic [7:0]         irq_v;
    logic [7:0]         rd_v;

    assign hit    = (bus.adr == IF_ADR);
    assign wr_hit = bus.wr && hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_bit
        sm83_irq_bit u_bit (
            .clk    (clk),
            .areset (areset),
            .req    (bus.src_req[i]),
            .wr_hit (wr_hit),
            .wdat   (bus.din[i]),
            .ack    (bus.iack[i]),
            .flag   (if_q[i])
        );
    end

    // Unimplemented IF bits read as 1 and never raise irq.
    always_comb begin
        irq_v                = '0;
        irq_v[NUM_SRC-1:0]   = if_q;
        rd_v                 = '1;
        rd_v[NUM_SRC-1:0]    = if_q;
    end

    assign bus.irq     = irq_v;
    assign bus.dout_oe = bus.rd && hit;
    assign bus.dout    = (bus.rd && hit) ? rd_v : 8'hFF;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             ena_q;
    logic             stable_q;
    logic             ena_fall;

    assign ena_fall       = ena_q && !bus.clk_ena;
    assign bus.clk_stable = stable_q;

    // Reaching the terminal count completes the pulse even if the core wakes on that edge;
    // a fresh clk_ena fall seen during the pulse restarts the count right behind it.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            st       <= IDLE;
            cnt      <= '0;
            ena_q    <= 1'b1;
            stable_q <= 1'b0;
        end else begin
            ena_q    <= bus.clk_ena;
            stable_q <= 1'b0;
            case (st)
                IDLE: begin
                    if (ena_fall) begin
                        st  <= COUNT;
                        cnt <= '0;
                    end
                end
                COUNT: begin
                    if (cnt == CNT_LAST) begin
                        st       <= STABLE;
                        stable_q <= 1'b1;
                    end else if (bus.clk_ena) begin
                        st <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (ena_fall) begin
                        st  <= COUNT;
                        cnt <= '0;
                    end else begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm83_irq_resp.sv
// Directed bench for sm83_irq_resp: stimulus queues expectations, a monitor checks them.
module tb_sm83_irq_resp;
    localparam int NUM_SRC = 5;

    logic clk = 1'b0;
    logic areset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] irq;
        logic [7:0] dout;
        logic       oe;
    } exp_t;

    exp_t sb[$];
    int   pulse_q[$];
    exp_t e;

    sm83_irq_resp_if #(.NUM_SRC(NUM_SRC)) bus ();

    sm83_irq_resp #(
        .NUM_SRC       (NUM_SRC),
        .IF_ADR        (16'hFF0F),
        .STABLE_CYCLES (16)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, "_stale"}, e.cyc, cyc);
            end else begin
                chk({e.name, "_irq"},     int'(bus.irq),     int'(e.irq));
                chk({e.name, "_dout"},    int'(bus.dout),    int'(e.dout));
                chk({e.name, "_dout_oe"}, int'(bus.dout_oe), int'(e.oe));
            end
        end
        while (pulse_q.size() > 0 && pulse_q[0] < cyc)
            chk("clk_stable_missing", cyc, pulse_q.pop_front());
        if (bus.clk_stable === 1'b1) begin
            if (pulse_q.size() > 0 && pulse_q[0] == cyc)
                chk("clk_stable_timing", cyc, pulse_q.pop_front());
            else
                chk("clk_stable_unexpected", 1, 0);
        end
        if (done) begin
            chk("sb_drained", sb.size(), 0);
            chk("pulse_drained", pulse_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_out(string nm, logic [7:0] irq_e, logic [7:0] dout_e, logic oe_e);
        exp_t x;
        x.cyc  = cyc;
        x.name = nm;
        x.irq  = irq_e;
        x.dout = dout_e;
        x.oe   = oe_e;
        sb.push_back(x);
    endtask

    task automatic write_if(logic [7:0] d);
        bus.adr = 16'hFF0F;
        bus.din = d;
        bus.wr  = 1'b1;
        tick();
        bus.wr  = 1'b0;
    endtask

    initial begin
        areset      = 1'b1;
        bus.adr     = 16'h0000;
        bus.din     = 8'h00;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.src_req = '0;
        bus.iack    = 8'h00;
        bus.clk_ena = 1'b1;
        tick(3);
        expect_out("reset", 8'h00, 8'hFF, 1'b0);
        tick();
        areset = 1'b0;
        tick();

        // request edge sets IF, readback has unimplemented bits high
        bus.src_req = 5'b00100;
        tick();
        bus.src_req = '0;
        bus.rd  = 1'b1;
        bus.adr = 16'hFF0F;
        expect_out("t1_read", 8'h04, 8'hE4, 1'b1);
        tick();
        bus.rd = 1'b0;

        write_if(8'h05);
        expect_out("t2_wr05", 8'h05, 8'hFF, 1'b0);
        bus.iack = 8'h01;
        tick();
        bus.iack = 8'h00;
        expect_out("t2_ack0", 8'h04, 8'hFF, 1'b0);
        bus.iack    = 8'h04;
        bus.src_req = 5'b00100;
        tick();
        bus.iack    = 8'h00;
        bus.src_req = '0;
        expect_out("t2_set_beats_ack", 8'h04, 8'hFF, 1'b0);
        bus.iack = 8'h04;
        tick();
        bus.iack = 8'h00;
        expect_out("t2_ack2", 8'h00, 8'hFF, 1'b0);

        write_if(8'hFF);
        expect_out("t3_wrFF", 8'h1F, 8'hFF, 1'b0);
        bus.rd  = 1'b1;
        bus.adr = 16'hFF0E;
        expect_out("t3_miss", 8'h1F, 8'hFF, 1'b0);
        tick();
        bus.adr = 16'hFF0F;
        expect_out("t3_hit", 8'h1F, 8'hFF, 1'b1);
        tick();
        bus.rd   = 1'b0;
        bus.iack = 8'hE0;
        tick();
        bus.iack = 8'h00;
        expect_out("t3_high_ack_ignored", 8'h1F, 8'hFF, 1'b0);

        // held request must not re-set a bit once acknowledged
        bus.src_req = 5'b00001;
        tick();
        bus.iack = 8'h01;
        tick();
        bus.iack = 8'h00;
        expect_out("t4_ack0", 8'h1E, 8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("t4_level_held", 8'h1E, 8'hFF, 1'b0);
        end
        bus.src_req = '0;

        bus.iack = 8'h01;
        write_if(8'h03);
        bus.iack = 8'h00;
        expect_out("t4_wr_beats_ack", 8'h03, 8'hFF, 1'b0);
        write_if(8'h00);
        expect_out("t4_clear", 8'h00, 8'hFF, 1'b0);

        // clock restart: pulse on the 17th edge after the fall
        bus.clk_ena = 1'b0;
        pulse_q.push_back(cyc + 17);
        tick(25);
        bus.clk_ena = 1'b1;
        tick(3);

        // wake during count aborts without a pulse
        bus.clk_ena = 1'b0;
        tick(5);
        bus.clk_ena = 1'b1;
        tick(25);

        // reset mid-count: no pulse and IF cleared despite a pending ack
        bus.src_req = 5'b00010;
        tick();
        bus.src_req = '0;
        expect_out("t6_if_set", 8'h02, 8'hFF, 1'b0);
        bus.clk_ena = 1'b0;
        tick(6);
        areset      = 1'b1;
        bus.iack    = 8'h02;
        bus.clk_ena = 1'b1;
        tick(2);
        expect_out("t6_reset_if", 8'h00, 8'hFF, 1'b0);
        areset   = 1'b0;
        bus.iack = 8'h00;
        tick(25);
        bus.rd  = 1'b1;
        bus.adr = 16'hFF0F;
        expect_out("t6_after_reset", 8'h00, 8'hE0, 1'b1);
        tick(2);
        bus.rd = 1'b0;
        done = 1'b1;
    end
endmodule
